xy_route_switch: RTL and testbench
==================================

XY_ROUTE_SWITCH -- requirements
Module: xy_route_switch

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- CHANNEL_NUMBER, 5, output port count.
- MAX_ROUTERS_X, 4, mesh columns.
- MAX_ROUTERS_Y, 4, mesh rows.
- ROUTER_X, 0, own column.
- ROUTER_Y, 0, own row.
- X_W = $clog2(MAX_ROUTERS_X), Y_W = $clog2(MAX_ROUTERS_Y), derived widths.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk_i, input, 1, clock.
- rst_n_i, input, 1, reset: asynchronous, active-low.
- in_mosi_i, input, axis_mosi_t, flit from upstream arbiter.
- in_miso_o, output, axis_miso_t, TREADY to upstream arbiter.
- target_x_i, input, X_W, arbiter-decoded target column.
- target_y_i, input, Y_W, arbiter-decoded target row.
- out_mosi_o[CHANNEL_NUMBER], output, axis_mosi_t, per-port flit.
- out_miso_i[CHANNEL_NUMBER], input, axis_miso_t, per-port TREADY.
- busy_o, output, 1, packet in progress.
- current_port_o, output, 3, locked port index.
- drop_o, output, 1, one-cycle pulse on a discarded stray flit.

Function
REQ-003 Port indices SHALL be: 0 local, 1 north, 2 east, 3 south, 4 west.
REQ-004 Route selection SHALL be XY, X first: target_x_i>ROUTER_X east; <ROUTER_X west; equal and target_y_i>ROUTER_Y north; <ROUTER_Y south; both equal local.
REQ-005 A header is an accepted flit (TVALID&TREADY) with TID==ROUTING_HEADER while in IDLE.
- LEN = TDATA[2*(X_W+Y_W)+7 : 2*(X_W+Y_W)] = payload beats following the header.
REQ-006 FSM SHALL have states IDLE and BODY.
- IDLE, header accepted: latch port, load 8-bit counter with LEN, go BODY if LEN!=0, else stay IDLE.
- BODY: each accepted flit decrements the counter; the flit with counter==1 returns to IDLE.
REQ-007 In BODY, framing SHALL be counter-based only; TID is not inspected, so a flit with TID==ROUTING_HEADER is forwarded as payload.
REQ-008 In IDLE, a non-header flit SHALL be accepted, not forwarded, and drop_o SHALL pulse for one cycle.
REQ-009 Each output port SHALL have a 2-entry skid buffer.
- Flit latency input to out_mosi_o: exactly 1 cycle when the buffer is empty.
- Full throughput: one flit per cycle per packet.
REQ-010 in_miso_o.TREADY SHALL be:
- IDLE: the skid ready of the port computed from current target_x_i/target_y_i.
- BODY: the skid ready of the locked port.
- In both states it is sourced from the registered skid state, with no combinational path from out_miso_i.
REQ-011 A header SHALL be accepted in the cycle after a packet's last beat, with no bubble required.
REQ-012 Flits to non-selected ports SHALL never assert TVALID; per-port TDATA/TID ordering SHALL be preserved.
REQ-013 Once TVALID is asserted on a port, it SHALL remain high with its data stable until TREADY.
REQ-014 Status outputs:
- busy_o = (state==BODY).
- current_port_o = locked port in BODY, 0 in IDLE.
REQ-015 LEN=255 SHALL be supported with no counter wrap.

Reset
REQ-016 Asynchronous reset SHALL force:
- state IDLE, counter 0, current_port_o 0, busy_o 0, drop_o 0;
- all skid buffers empty and all out_mosi_o.TVALID 0.
REQ-017 Reset mid-packet SHALL discard buffered flits; after release, the first accepted flit is treated as a header candidate.

Structure
REQ-018 axis_mosi_t, axis_miso_t, ROUTING_HEADER, the port index constants and the header field offsets SHALL live in the shared axis_type package/header.
REQ-019 The per-port buffer SHALL be the sub-module axis_skid_buffer, instantiated CHANNEL_NUMBER times via generate.

Verification (ROUTER_X=1, ROUTER_Y=1, 4x4)
REQ-020 Header target (3,1), LEN=3, all ports ready -> 4 flits appear on port 2 on consecutive cycles, starting 1 cycle after input; busy_o high for 3 cycles.
REQ-021 Headers to (1,1), (1,0), (0,2) -> packets on ports 0, 3 and 4 respectively.
REQ-022 LEN=0 header to (1,3), immediately followed by a header to (2,1) -> one flit on port 1, then the second packet on port 2; no bubble between them.
REQ-023 Port 2 TREADY held low for 5 cycles mid-packet -> in_miso_o.TREADY drops within 2 accepted beats; no flit lost or duplicated; port 2 TVALID/TDATA stable throughout.
REQ-024 Non-header flit in IDLE -> drop_o pulses once, no port TVALID; a later header with TID==ROUTING_HEADER inside a LEN=2 body -> forwarded as payload.
REQ-025 rst_n_i asserted after 2 of 5 payload beats -> all TVALID 0 immediately; a new header after release routes correctly.

Source files
------------

// File: rtl/xy_route_switch_pkg.sv
// Shared AXI-stream flit types, header encoding and port numbering for the mesh router.
package xy_route_switch_pkg;

  localparam int DATA_W = 32;
  localparam int ID_W   = 2;
  localparam int LEN_W  = 8;

  localparam logic [ID_W-1:0] ROUTING_HEADER = 2'd1;

  localparam logic [2:0] PORT_LOCAL = 3'd0;
  localparam logic [2:0] PORT_NORTH = 3'd1;
  localparam logic [2:0] PORT_EAST  = 3'd2;
  localparam logic [2:0] PORT_SOUTH = 3'd3;
  localparam logic [2:0] PORT_WEST  = 3'd4;

  typedef struct packed {
    logic [DATA_W-1:0] tdata;
    logic [ID_W-1:0]   tid;
    logic              tvalid;
  } axis_mosi_t;

  typedef struct packed {
    logic tready;
  } axis_miso_t;

  typedef enum logic {ST_IDLE, ST_BODY} route_state_t;

  // Header carries source and destination coordinates below the payload length field.
  function automatic int hdr_len_lsb(input int x_w, input int y_w);
    return 2 * (x_w + y_w);
  endfunction

endpackage

// File: rtl/xy_route_switch_if.sv
// Bundle of the switch input flit, decoded target and the per-port output streams.
interface xy_route_switch_if #(
  parameter int CHANNEL_NUMBER = 5,
  parameter int X_W            = 2,
  parameter int Y_W            = 2
);
  import xy_route_switch_pkg::*;

  axis_mosi_t     in_mosi_i;
  axis_miso_t     in_miso_o;
  logic [X_W-1:0] target_x_i;
  logic [Y_W-1:0] target_y_i;
  axis_mosi_t     out_mosi_o [CHANNEL_NUMBER];
  axis_miso_t     out_miso_i [CHANNEL_NUMBER];

  modport slave (
    input  in_mosi_i, target_x_i, target_y_i, out_miso_i,
    output in_miso_o, out_mosi_o
  );

  modport master (
    output in_mosi_i, target_x_i, target_y_i, out_miso_i,
    input  in_miso_o, out_mosi_o
  );

endinterface

// File: rtl/xy_route_switch_skid.sv
// Two-entry skid buffer: one-cycle latency when empty, ready derived only from registered state.
module axis_skid_buffer
  import xy_route_switch_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [DATA_W-1:0] in_data,
  input  logic [ID_W-1:0]   in_id,
  input  logic              in_valid,
  output logic              in_ready,
  output axis_mosi_t        out_mosi,
  input  logic              out_ready
);

  logic              main_valid_reg;
  logic              skid_valid_reg;
  logic [DATA_W-1:0] main_data_reg;
  logic [DATA_W-1:0] skid_data_reg;
  logic [ID_W-1:0]   main_id_reg;
  logic [ID_W-1:0]   skid_id_reg;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      main_valid_reg <= 1'b0;
      skid_valid_reg <= 1'b0;
      main_data_reg  <= '0;
      skid_data_reg  <= '0;
      main_id_reg    <= '0;
      skid_id_reg    <= '0;
    end else if (!main_valid_reg || out_ready) begin
      // Output slot is free this cycle: refill from the skid first to keep order.
      if (skid_valid_reg) begin
        main_valid_reg <= 1'b1;
        main_data_reg  <= skid_data_reg;
        main_id_reg    <= skid_id_reg;
        skid_valid_reg <= 1'b0;
      end else begin
        main_valid_reg <= in_valid;
        main_data_reg  <= in_data;
        main_id_reg    <= in_id;
      end
    end else if (in_valid && !skid_valid_reg) begin
      skid_valid_reg <= 1'b1;
      skid_data_reg  <= in_data;
      skid_id_reg    <= in_id;
    end
  end

  assign in_ready        = !skid_valid_reg;
  assign out_mosi.tdata  = main_data_reg;
  assign out_mosi.tid    = main_id_reg;
  assign out_mosi.tvalid = main_valid_reg;

endmodule

// File: rtl/xy_route_switch.sv
// XY (column-first) packet switch: locks an output port per packet and frames the body by length.
module xy_route_switch
  import xy_route_switch_pkg::*;
#(
  parameter int CHANNEL_NUMBER = 5,
  parameter int MAX_ROUTERS_X  = 4,
  parameter int MAX_ROUTERS_Y  = 4,
  parameter int ROUTER_X       = 0,
  parameter int ROUTER_Y       = 0,
  localparam int X_W           = $clog2(MAX_ROUTERS_X),
  localparam int Y_W           = $clog2(MAX_ROUTERS_Y)
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  xy_route_switch_if.slave   sw,
  output logic               busy_o,
  output logic [2:0]         current_port_o,
  output logic               drop_o
);

  localparam logic [X_W-1:0] OWN_X   = X_W'(ROUTER_X);
  localparam logic [Y_W-1:0] OWN_Y   = Y_W'(ROUTER_Y);
  localparam int             LEN_LSB = hdr_len_lsb(X_W, Y_W);

  function automatic logic [2:0] xy_route(input logic [X_W-1:0] tx, input logic [Y_W-1:0] ty);
    if (tx > OWN_X)      return PORT_EAST;
    else if (tx < OWN_X) return PORT_WEST;
    else if (ty > OWN_Y) return PORT_NORTH;
    else if (ty < OWN_Y) return PORT_SOUTH;
    else                 return PORT_LOCAL;
  endfunction

  route_state_t            state_reg, state_next;
  logic [LEN_W-1:0]        cnt_reg, cnt_next;
  logic [2:0]              port_reg, port_next;
  logic                    drop_reg, drop_next;
  logic                    fwd;
  logic [2:0]              route_port, sel_port;
  logic [CHANNEL_NUMBER-1:0] skid_ready, push;
  logic [7:0]              ready_vec;
  logic                    in_ready, accept, is_hdr;
  logic [LEN_W-1:0]        hdr_len;
  axis_mosi_t              out_mosi [CHANNEL_NUMBER];

  assign route_port = xy_route(sw.target_x_i, sw.target_y_i);
  assign sel_port   = (state_reg == ST_BODY) ? port_reg : route_port;
  assign is_hdr     = (sw.in_mosi_i.tid == ROUTING_HEADER);
  assign hdr_len    = sw.in_mosi_i.tdata[LEN_LSB +: LEN_W];

  // Padded so a 3-bit port index can address the vector for any channel count.
  always_comb begin
    ready_vec = '0;
    ready_vec[CHANNEL_NUMBER-1:0] = skid_ready;
  end

  assign in_ready     = ready_vec[sel_port];
  assign sw.in_miso_o = '{tready: in_ready};
  assign accept       = sw.in_mosi_i.tvalid && in_ready;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    port_next  = port_reg;
    drop_next  = 1'b0;
    fwd        = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          if (is_hdr) begin
            fwd       = 1'b1;
            port_next = route_port;
            cnt_next  = hdr_len;
            if (hdr_len != '0) state_next = ST_BODY;
          end else begin
            drop_next = 1'b1;
          end
        end
      end
      ST_BODY: begin
        // Body framing is purely by count; TID is passed through untouched.
        if (accept) begin
          fwd      = 1'b1;
          cnt_next = cnt_reg - 8'd1;
          if (cnt_reg == 8'd1) state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      port_reg  <= PORT_LOCAL;
      drop_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      port_reg  <= port_next;
      drop_reg  <= drop_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < CHANNEL_NUMBER; gi++) begin : g_port
      assign push[gi] = fwd && (sel_port == 3'(gi));

      axis_skid_buffer u_skid (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .in_data   (sw.in_mosi_i.tdata),
        .in_id     (sw.in_mosi_i.tid),
        .in_valid  (push[gi]),
        .in_ready  (skid_ready[gi]),
        .out_mosi  (out_mosi[gi]),
        .out_ready (sw.out_miso_i[gi].tready)
      );
    end
  endgenerate

  assign sw.out_mosi_o   = out_mosi;
  assign busy_o          = (state_reg == ST_BODY);
  assign current_port_o  = busy_o ? port_reg : PORT_LOCAL;
  assign drop_o          = drop_reg;

endmodule

// File: tb/tb_xy_route_switch.sv
// Self-checking bench for xy_route_switch at router (1,1) of a 4x4 mesh, against a queue-level model.
module tb_xy_route_switch;
  import xy_route_switch_pkg::*;

  localparam int NP = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  xy_route_switch_if #(.CHANNEL_NUMBER(NP), .X_W(2), .Y_W(2)) sw();
  logic       busy, drop;
  logic [2:0] cur_port;

  xy_route_switch #(
    .CHANNEL_NUMBER(NP), .MAX_ROUTERS_X(4), .MAX_ROUTERS_Y(4), .ROUTER_X(1), .ROUTER_Y(1)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n), .sw(sw),
    .busy_o(busy), .current_port_o(cur_port), .drop_o(drop)
  );

  typedef struct packed {
    logic [31:0] d;
    logic [1:0]  id;
  } flit_t;

  // Reference model: each port is a 2-deep FIFO, framing tracked as remaining beat count.
  flit_t mq [NP][$];
  bit    m_busy;
  int    m_rem;
  int    m_lock;
  bit    m_drop;

  logic [NP-1:0] forced_rdy = '1;
  bit  rand_rdy = 1'b0;
  bit  gaps = 1'b0;
  int  cyc = 0;
  int  n_chk = 0;
  int  n_err = 0;
  int  fires [NP][$];
  int  drop_cnt = 0;
  int  busy_cnt = 0;

  function automatic int route(input int tx, input int ty);
    if (tx > 1) return 2;
    if (tx < 1) return 4;
    if (ty > 1) return 1;
    if (ty < 1) return 3;
    return 0;
  endfunction

  function automatic bit m_ready();
    int p;
    p = m_busy ? m_lock : route(int'(sw.target_x_i), int'(sw.target_y_i));
    return mq[p].size() < 2;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #2;
    for (int i = 0; i < NP; i++)
      sw.out_miso_i[i].tready = rand_rdy ? ($urandom_range(0, 3) != 0) : forced_rdy[i];
  end

  always @(posedge clk or negedge rst_n) begin : model
    bit    acc;
    flit_t f;
    if (!rst_n) begin
      for (int i = 0; i < NP; i++) mq[i].delete();
      m_busy = 1'b0;
      m_rem  = 0;
      m_lock = 0;
      m_drop = 1'b0;
    end else begin
      acc = sw.in_mosi_i.tvalid && m_ready();
      for (int i = 0; i < NP; i++)
        if (mq[i].size() > 0 && sw.out_miso_i[i].tready) void'(mq[i].pop_front());
      m_drop = 1'b0;
      f.d  = sw.in_mosi_i.tdata;
      f.id = sw.in_mosi_i.tid;
      if (acc) begin
        if (!m_busy) begin
          if (f.id == ROUTING_HEADER) begin
            m_lock = route(int'(sw.target_x_i), int'(sw.target_y_i));
            m_rem  = int'(f.d[15:8]);
            mq[m_lock].push_back(f);
            m_busy = (m_rem != 0);
          end else begin
            m_drop = 1'b1;
          end
        end else begin
          mq[m_lock].push_back(f);
          m_rem--;
          if (m_rem == 0) m_busy = 1'b0;
        end
      end
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic compare_loop();
    forever begin
      @(negedge clk);
      for (int i = 0; i < NP; i++) begin
        bit ev;
        ev = mq[i].size() > 0;
        chk($sformatf("tvalid[%0d]", i), longint'(sw.out_mosi_o[i].tvalid), longint'(ev));
        if (ev) begin
          chk($sformatf("tdata[%0d]", i), longint'(sw.out_mosi_o[i].tdata), longint'(mq[i][0].d));
          chk($sformatf("tid[%0d]", i), longint'(sw.out_mosi_o[i].tid), longint'(mq[i][0].id));
        end
        if (rst_n && sw.out_mosi_o[i].tvalid && sw.out_miso_i[i].tready) fires[i].push_back(cyc + 1);
      end
      chk("in_tready", longint'(sw.in_miso_o.tready), longint'(m_ready()));
      chk("busy", longint'(busy), longint'(m_busy));
      chk("current_port", longint'(cur_port), m_busy ? longint'(m_lock) : 0);
      chk("drop", longint'(drop), longint'(m_drop));
      if (drop) drop_cnt++;
      if (busy) busy_cnt++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d, input logic [1:0] id, input int tx, input int ty,
                      output int acc_e);
    bit rdy;
    rdy = 1'b0;
    acc_e = -1;
    sw.in_mosi_i.tvalid = 1'b1;
    sw.in_mosi_i.tdata  = d;
    sw.in_mosi_i.tid    = id;
    sw.target_x_i       = 2'(tx);
    sw.target_y_i       = 2'(ty);
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      rdy = sw.in_miso_o.tready;
      @(posedge clk);
      #1;
      if (rdy) begin
        acc_e = cyc;
        break;
      end
    end
    sw.in_mosi_i.tvalid = 1'b0;
    chk("send_accepted_within_budget", longint'(rdy), 1);
  endtask

  task automatic send_pkt(input int tx, input int ty, input int len, input bit hdr_payload,
                          output int hdr_e);
    logic [31:0] d;
    logic [1:0]  pid;
    int          e;
    d = $urandom;
    d[15:8] = 8'(len);
    send(d, ROUTING_HEADER, tx, ty, hdr_e);
    $display("pkt target=(%0d,%0d) len=%0d port=%0d accepted_at=%0d", tx, ty, len, route(tx, ty), hdr_e);
    for (int i = 0; i < len; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) tick();
      pid = hdr_payload ? ROUTING_HEADER : 2'($urandom_range(0, 3));
      send($urandom, pid, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), e);
    end
  endtask

  task automatic drain();
    repeat (8) tick();
  endtask

  function automatic int total_fires();
    int t;
    t = 0;
    for (int i = 0; i < NP; i++) t += fires[i].size();
    return t;
  endfunction

  initial begin
    int he, e1, e2, b0, b1, b2, b3, b4, bb, bd, bt;
    logic [31:0] d;
    sw.in_mosi_i  = '0;
    sw.target_x_i = '0;
    sw.target_y_i = '0;

    fork
      compare_loop();
    join_none
    fork
      begin
        #600000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
      end
    join_none

    #3 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    @(negedge clk);
    chk("reset_busy", longint'(busy), 0);
    chk("reset_current_port", longint'(cur_port), 0);
    chk("reset_drop", longint'(drop), 0);
    chk("reset_in_tready", longint'(sw.in_miso_o.tready), 1);
    for (int i = 0; i < NP; i++) chk($sformatf("reset_tvalid[%0d]", i), longint'(sw.out_mosi_o[i].tvalid), 0);
    tick();

    // Header to (3,1), LEN=3: four consecutive flits on east, one cycle after the header.
    b2 = fires[2].size();
    bb = busy_cnt;
    send_pkt(3, 1, 3, 1'b0, he);
    drain();
    chk("east_flit_count", fires[2].size() - b2, 4);
    chk("east_first_fire", fires[2][b2], he + 1);
    chk("east_last_fire", fires[2][b2 + 3], he + 4);
    chk("east_busy_cycles", busy_cnt - bb, 3);

    b0 = fires[0].size(); b3 = fires[3].size(); b4 = fires[4].size(); b2 = fires[2].size();
    send_pkt(1, 1, 2, 1'b0, he);
    send_pkt(1, 0, 2, 1'b0, he);
    send_pkt(0, 2, 2, 1'b0, he);
    drain();
    chk("local_count", fires[0].size() - b0, 3);
    chk("south_count", fires[3].size() - b3, 3);
    chk("west_count", fires[4].size() - b4, 3);
    chk("east_untouched", fires[2].size() - b2, 0);

    // LEN=0 header straight into the next header: no bubble.
    b1 = fires[1].size(); b2 = fires[2].size();
    send_pkt(1, 3, 0, 1'b0, e1);
    send_pkt(2, 1, 1, 1'b0, e2);
    drain();
    chk("back_to_back_headers", e2 - e1, 1);
    chk("north_single_flit", fires[1].size() - b1, 1);
    chk("north_fire_edge", fires[1][b1], e1 + 1);
    chk("east_after_len0", fires[2].size() - b2, 2);
    chk("east_after_len0_edge", fires[2][b2], e2 + 1);

    // Output stall on east mid-packet.
    b2 = fires[2].size();
    fork
      send_pkt(3, 1, 8, 1'b0, he);
      begin
        int k, acc_during;
        bit saw_low;
        logic [31:0] held;
        k = 0; acc_during = 0; saw_low = 1'b0; held = '0;
        while (fires[2].size() < b2 + 2 && k < 100) begin
          @(negedge clk);
          k++;
        end
        @(posedge clk);
        #1 forced_rdy[2] = 1'b0;
        for (int s = 0; s < 5; s++) begin
          @(negedge clk);
          if (s == 0) held = sw.out_mosi_o[2].tdata;
          chk("stall_tvalid_held", longint'(sw.out_mosi_o[2].tvalid), 1);
          if (s > 0) chk("stall_tdata_stable", longint'(sw.out_mosi_o[2].tdata), longint'(held));
          if (sw.in_mosi_i.tvalid && sw.in_miso_o.tready) acc_during++;
          if (!sw.in_miso_o.tready) saw_low = 1'b1;
        end
        @(posedge clk);
        #1 forced_rdy[2] = 1'b1;
        chk("stall_tready_dropped", longint'(saw_low), 1);
        chk("stall_accepted_le2", longint'(acc_during <= 2), 1);
      end
    join
    drain();
    chk("stall_east_count", fires[2].size() - b2, 9);

    // Stray flit in IDLE, then header-TID beats inside a body.
    bd = drop_cnt;
    bt = total_fires();
    send(32'h1234_5678, 2'd0, 3, 1, e1);
    $display("stray tid=0 accepted_at=%0d", e1);
    drain();
    chk("stray_drop_pulses", drop_cnt - bd, 1);
    chk("stray_not_forwarded", total_fires() - bt, 0);
    b1 = fires[1].size();
    send_pkt(1, 3, 2, 1'b1, he);
    drain();
    chk("hdr_tid_payload_count", fires[1].size() - b1, 3);
    chk("hdr_tid_no_drop", drop_cnt - bd, 1);

    // Reset after 2 of 5 payload beats.
    d = $urandom;
    d[15:8] = 8'd5;
    send(d, ROUTING_HEADER, 1, 0, he);
    $display("pkt target=(1,0) len=5 port=3 accepted_at=%0d (reset after 2 beats)", he);
    send($urandom, 2'd0, 0, 0, e1);
    send($urandom, 2'd0, 0, 0, e1);
    chk("pre_reset_south_tvalid", longint'(sw.out_mosi_o[3].tvalid), 1);
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < NP; i++) chk($sformatf("midreset_tvalid[%0d]", i), longint'(sw.out_mosi_o[i].tvalid), 0);
    chk("midreset_busy", longint'(busy), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    b2 = fires[2].size();
    send_pkt(3, 3, 2, 1'b0, he);
    drain();
    chk("post_reset_east_count", fires[2].size() - b2, 3);

    // Longest packet.
    b4 = fires[4].size();
    bb = busy_cnt;
    send_pkt(0, 1, 255, 1'b0, he);
    drain();
    chk("len255_west_count", fires[4].size() - b4, 256);
    chk("len255_busy_cycles", busy_cnt - bb, 255);

    // Randomised traffic with random back-pressure and input gaps.
    rand_rdy = 1'b1;
    gaps = 1'b1;
    for (int n = 0; n < 100; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        logic [1:0] sid;
        sid = 2'($urandom_range(0, 2));
        if (sid == ROUTING_HEADER) sid = 2'd3;
        send($urandom, sid, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), e1);
        $display("stray tid=%0d accepted_at=%0d", sid, e1);
      end else begin
        send_pkt(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 6)), 1'b0, he);
      end
      if ($urandom_range(0, 2) == 0) tick();
    end
    rand_rdy = 1'b0;
    gaps = 1'b0;
    drain();
    chk("final_idle", longint'(busy), 0);
    chk("final_drained", total_fires() > 0 && sw.out_mosi_o[2].tvalid == 1'b0, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
